// File: rtl/proc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : proc_seq_pkg
// Brief  : Register map, STATUS/CTRL bit indices, mode encodings and sequencer
//          states shared by the proc_seq_ctrl block.
// Rev    : 1.0
// ============================================================================
package proc_seq_pkg;

  localparam logic [7:0] ADDR_MODE   = 8'h00;
  localparam logic [7:0] ADDR_KERN0  = 8'h04;
  localparam logic [7:0] ADDR_KERN1  = 8'h08;
  localparam logic [7:0] ADDR_KERN2  = 8'h0C;
  localparam logic [7:0] ADDR_STATUS = 8'h10;
  localparam logic [7:0] ADDR_CTRL   = 8'h14;
  localparam logic [7:0] ADDR_FCNT   = 8'h18;
  localparam logic [7:0] ADDR_IRQEN  = 8'h1C;

  localparam int STAT_DONE     = 0;
  localparam int STAT_ABORT    = 1;
  localparam int STAT_ERR_MODE = 2;
  localparam int STAT_ERR_BUSY = 3;
  localparam int STAT_BUSY     = 4;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CONT  = 2;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_CONV   = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/proc_seq_regs.sv
`default_nettype none
// ============================================================================
// Module : proc_seq_regs
// Brief  : CSR decode, shadow/active configuration, W1C STATUS, frame counter
//          and registered read mux. Optional irq under PROC_SEQ_CTRL_IRQ_EN.
// Rev    : 1.0
// ============================================================================
module proc_seq_regs
  import proc_seq_pkg::*;
#(
  parameter logic [71:0] KERNEL_RST = 72'h00_0000_0001_0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  csr_addr,
  input  logic        csr_wr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_rd,
  output logic [31:0] csr_rdata,
  output logic        csr_rvalid,
  input  logic        busy,
  input  logic        load,
  input  logic        ev_done,
  input  logic        ev_abort,
  input  logic        ev_err_busy,
  output logic        start_req,
  output logic        stop_req,
  output logic        cont,
  output logic [1:0]  mode,
  output logic [71:0] kernel
`ifdef PROC_SEQ_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic [1:0]  mode_sh_q, mode_sh_d, mode_q, mode_d;
  logic [71:0] kern_sh_q, kern_sh_d, kern_q, kern_d;
  logic [3:0]  status_q, status_d, status_set, status_clr;
  logic        cont_q, cont_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [31:0] rdata_q, rdata_d, rd_mux;
  logic        rvalid_q;
  logic        wr_mode, wr_ctrl, mode_bad;
`ifdef PROC_SEQ_CTRL_IRQ_EN
  logic [2:0]  irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
`endif

  always_comb begin
    wr_mode    = csr_wr && (csr_addr == ADDR_MODE);
    wr_ctrl    = csr_wr && (csr_addr == ADDR_CTRL);
    mode_bad   = wr_mode && (csr_wdata[1:0] == MODE_RSVD);
    start_req  = wr_ctrl && csr_wdata[CTRL_START];
    stop_req   = wr_ctrl && csr_wdata[CTRL_STOP];

    mode_sh_d  = mode_sh_q;
    kern_sh_d  = kern_sh_q;
    if (wr_mode && !mode_bad) mode_sh_d = csr_wdata[1:0];
    if (csr_wr && (csr_addr == ADDR_KERN0)) kern_sh_d[31:0]  = csr_wdata;
    if (csr_wr && (csr_addr == ADDR_KERN1)) kern_sh_d[63:32] = csr_wdata;
    if (csr_wr && (csr_addr == ADDR_KERN2)) kern_sh_d[71:64] = csr_wdata[7:0];

    // Active configuration only moves at the frame boundary
    mode_d     = load ? mode_sh_q : mode_q;
    kern_d     = load ? kern_sh_q : kern_q;
    cont_d     = wr_ctrl ? csr_wdata[CTRL_CONT] : cont_q;

    status_set                = '0;
    status_set[STAT_DONE]     = ev_done;
    status_set[STAT_ABORT]    = ev_abort;
    status_set[STAT_ERR_MODE] = mode_bad;
    status_set[STAT_ERR_BUSY] = ev_err_busy;
    status_clr = (csr_wr && (csr_addr == ADDR_STATUS)) ? csr_wdata[3:0] : 4'd0;
    status_d   = (status_q & ~status_clr) | status_set;

    fcnt_d     = fcnt_q + 16'(ev_done);
  end

`ifdef PROC_SEQ_CTRL_IRQ_EN
  always_comb begin
    irq_en_d = (csr_wr && (csr_addr == ADDR_IRQEN)) ? csr_wdata[2:0] : irq_en_q;
    irq_d    = (status_d[STAT_DONE] && irq_en_d[0]) ||
               (status_d[STAT_ABORT] && irq_en_d[1]) ||
               ((status_d[STAT_ERR_MODE] || status_d[STAT_ERR_BUSY]) && irq_en_d[2]);
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      ADDR_MODE:   rd_mux = {30'd0, mode_sh_q};
      ADDR_KERN0:  rd_mux = kern_sh_q[31:0];
      ADDR_KERN1:  rd_mux = kern_sh_q[63:32];
      ADDR_KERN2:  rd_mux = {24'd0, kern_sh_q[71:64]};
      ADDR_STATUS: rd_mux = {27'd0, busy, status_q};
      ADDR_CTRL:   rd_mux = {29'd0, cont_q, 2'b00};
      ADDR_FCNT:   rd_mux = {16'd0, fcnt_q};
`ifdef PROC_SEQ_CTRL_IRQ_EN
      ADDR_IRQEN:  rd_mux = {29'd0, irq_en_q};
`endif
      default:     rd_mux = '0;
    endcase
    rdata_d = csr_rd ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_sh_q <= MODE_BYPASS;
      mode_q    <= MODE_BYPASS;
      kern_sh_q <= KERNEL_RST;
      kern_q    <= KERNEL_RST;
      status_q  <= '0;
      cont_q    <= 1'b0;
      fcnt_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      mode_sh_q <= mode_sh_d;
      mode_q    <= mode_d;
      kern_sh_q <= kern_sh_d;
      kern_q    <= kern_d;
      status_q  <= status_d;
      cont_q    <= cont_d;
      fcnt_q    <= fcnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= csr_rd;
    end
  end

`ifdef PROC_SEQ_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  assign mode       = mode_q;
  assign kernel     = kern_q;
  assign cont       = cont_q;
  assign csr_rdata  = rdata_q;
  assign csr_rvalid = rvalid_q;

endmodule
`default_nettype wire

// File: rtl/proc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : proc_seq_ctrl
// Brief  : Frame sequencer: admits one IMG_W*IMG_H frame per run, detects
//          drain completion, commits configuration at frame boundaries.
//          Optional irq output under PROC_SEQ_CTRL_IRQ_EN.
// Rev    : 1.0
// ============================================================================
module proc_seq_ctrl
  import proc_seq_pkg::*;
#(
  parameter int          IMG_W        = 32,
  parameter int          IMG_H        = 32,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [71:0] KERNEL_RST   = 72'h00_0000_0001_0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  csr_addr,
  input  logic        csr_wr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_rd,
  output logic [31:0] csr_rdata,
  output logic        csr_rvalid,
  input  logic        prod_valid,
  output logic        prod_ready,
  output logic        dp_valid,
  input  logic        dp_ready,
  input  logic        dp_out_valid,
  input  logic        dp_out_ready,
  output logic [1:0]  mode,
  output logic [71:0] kernel,
  output logic        busy,
  output logic        frame_done
`ifdef PROC_SEQ_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int                PIX_N     = IMG_W * IMG_H;
  localparam int                PIX_W     = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_N - 1);
  localparam int                IDLE_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_CYCLES - 1);

  seq_state_t        state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              start_req, stop_req, cont, load;
  logic              ev_abort, ev_err_busy, beat;

  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign frame_done = (state_q == ST_DONE);
  assign load       = (state_q == ST_LOAD);
  assign beat       = prod_valid && dp_ready;

  proc_seq_regs #(
    .KERNEL_RST (KERNEL_RST)
  ) u_regs (
    .clk         (clk),
    .rstn        (rstn),
    .csr_addr    (csr_addr),
    .csr_wr      (csr_wr),
    .csr_wdata   (csr_wdata),
    .csr_rd      (csr_rd),
    .csr_rdata   (csr_rdata),
    .csr_rvalid  (csr_rvalid),
    .busy        (busy),
    .load        (load),
    .ev_done     (frame_done),
    .ev_abort    (ev_abort),
    .ev_err_busy (ev_err_busy),
    .start_req   (start_req),
    .stop_req    (stop_req),
    .cont        (cont),
    .mode        (mode),
    .kernel      (kernel)
`ifdef PROC_SEQ_CTRL_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    idle_d      = idle_q;
    prod_ready  = 1'b0;
    dp_valid    = 1'b0;
    // STOP outranks START, so a combined write never counts as a busy error
    ev_abort    = busy && stop_req;
    ev_err_busy = busy && start_req && !stop_req;

    case (state_q)
      ST_IDLE: begin
        if (start_req && !stop_req) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pix_d   = '0;
        idle_d  = '0;
        state_d = stop_req ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        prod_ready = dp_ready;
        dp_valid   = prod_valid;
        idle_d     = '0;
        if (stop_req) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          pix_d = pix_q + PIX_W'(1);
          if (pix_q == PIX_LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (stop_req) begin
          state_d = ST_IDLE;
        end else if (dp_out_valid && dp_out_ready) begin
          idle_d = '0;
        end else if (dp_out_ready) begin
          if (idle_q == IDLE_LAST) state_d = ST_DONE;
          else                     idle_d  = idle_q + IDLE_W'(1);
        end
      end
      ST_DONE: begin
        if (stop_req)                         state_d = ST_IDLE;
        else if (cont || start_req)           state_d = ST_LOAD;
        else                                  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      idle_q  <= idle_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_proc_seq_ctrl
// Brief  : Directed, table-driven bench for proc_seq_ctrl (CSR map, frame
//          admission, drain detection, STOP/CONT/reset corner cases).
// Rev    : 1.0
// ============================================================================
module tb_proc_seq_ctrl;

  localparam logic [71:0] KRST = 72'h00_0000_0001_0000_0000;
  localparam logic [71:0] K1   = {8'hFF, 32'h0000_0001, 32'hAABB_CCDD};
  localparam logic [71:0] K2   = {8'hFF, 32'h0000_0001, 32'hFFFF_FFFF};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  csr_addr = '0;
  logic        csr_wr = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic        csr_rd = 1'b0;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        prod_valid = 1'b0;
  logic        prod_ready;
  logic        dp_valid;
  logic        dp_ready = 1'b0;
  logic        dp_out_valid = 1'b0;
  logic        dp_out_ready = 1'b0;
  logic [1:0]  mode;
  logic [71:0] kernel;
  logic        busy;
  logic        frame_done;
`ifdef PROC_SEQ_CTRL_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  proc_seq_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .csr_addr     (csr_addr),
    .csr_wr       (csr_wr),
    .csr_wdata    (csr_wdata),
    .csr_rd       (csr_rd),
    .csr_rdata    (csr_rdata),
    .csr_rvalid   (csr_rvalid),
    .prod_valid   (prod_valid),
    .prod_ready   (prod_ready),
    .dp_valid     (dp_valid),
    .dp_ready     (dp_ready),
    .dp_out_valid (dp_out_valid),
    .dp_out_ready (dp_out_ready),
    .mode         (mode),
    .kernel       (kernel),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef PROC_SEQ_CTRL_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [7:0]  a;
    logic        wr;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t tv [17];
  wr_t  sched [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
    csr_addr = a; csr_wdata = d; csr_wr = 1'b1;
    @(posedge clk); #1;
    csr_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
    csr_addr = a; csr_rd = 1'b1;
    @(posedge clk); #1;
    csr_rd = 1'b0;
    chk("rvalid", csr_rvalid, 1'b1);
    d = csr_rdata;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    csr_read(a, v);
    chk(nm, v, exp);
  endtask

  task automatic clear_sched();
    for (int k = 0; k < 3; k++) sched[k] = '{-1, 8'h00, 32'h0};
  endtask

  // Entry state is LOAD; streams until target beats are admitted.
  task automatic stream(input int target, input bit rnd, input bit gate_chk, input string nm);
    int beats = 0;
    int cyc   = 0;
    int bad   = 0;
    prod_valid = 1'b1;
    while (beats < target && cyc < 4000) begin
      dp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      csr_wr   = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (sched[k].cyc == cyc) begin
          csr_wr = 1'b1; csr_addr = sched[k].a; csr_wdata = sched[k].d;
        end
      end
      #1;
      if ((prod_ready && prod_valid) != (dp_valid && dp_ready)) bad++;
      if (dp_valid && dp_ready) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    csr_wr = 1'b0;
    dp_ready = 1'b1;
    #1;
    chk({nm, " beats"}, beats, target);
    chk({nm, " handshake"}, bad, 0);
    if (gate_chk) chk({nm, " gate closed"}, {prod_ready, dp_valid}, 2'b00);
    clear_sched();
  endtask

  // pre idle cycles, nb output beats, stall cycles with ready low, then idle.
  task automatic drain(input int pre, input int nb, input int stall, input int exp_edges, input string nm);
    int edges = 0;
    bit seen  = 1'b0;
    prod_valid = 1'b0;
    dp_ready   = 1'b1;
    for (int i = 0; i < exp_edges + 20 && !seen; i++) begin
      if (i < pre)                   begin dp_out_valid = 1'b0; dp_out_ready = 1'b1; end
      else if (i < pre + nb)         begin dp_out_valid = 1'b1; dp_out_ready = 1'b1; end
      else if (i < pre + nb + stall) begin dp_out_valid = 1'b0; dp_out_ready = 1'b0; end
      else                           begin dp_out_valid = 1'b0; dp_out_ready = 1'b1; end
      @(posedge clk); #1;
      edges++;
      if (frame_done) seen = 1'b1;
    end
    dp_out_valid = 1'b0;
    dp_out_ready = 1'b1;
    chk({nm, " drain edges"}, edges, exp_edges);
    @(posedge clk); #1;
    chk({nm, " done pulse width"}, frame_done, 1'b0);
  endtask

  initial begin
    tv[0]  = '{8'h00, 1'b0, 32'h0,         32'h0};
    tv[1]  = '{8'h04, 1'b0, 32'h0,         32'h0};
    tv[2]  = '{8'h08, 1'b0, 32'h0,         32'h1};
    tv[3]  = '{8'h0C, 1'b0, 32'h0,         32'h0};
    tv[4]  = '{8'h18, 1'b0, 32'h0,         32'h0};
    tv[5]  = '{8'h00, 1'b1, 32'h1,         32'h1};
    tv[6]  = '{8'h00, 1'b1, 32'h3,         32'h1};
    tv[7]  = '{8'h10, 1'b0, 32'h0,         32'h4};
    tv[8]  = '{8'h10, 1'b1, 32'h4,         32'h0};
    tv[9]  = '{8'h04, 1'b1, 32'hAABB_CCDD, 32'hAABB_CCDD};
    tv[10] = '{8'h0C, 1'b1, 32'h1FF,       32'hFF};
    tv[11] = '{8'h40, 1'b1, 32'h123,       32'h0};
    tv[12] = '{8'h14, 1'b1, 32'h2,         32'h0};
    tv[13] = '{8'h10, 1'b0, 32'h0,         32'h0};
`ifdef PROC_SEQ_CTRL_IRQ_EN
    tv[14] = '{8'h1C, 1'b1, 32'h7,         32'h7};
`else
    tv[14] = '{8'h1C, 1'b1, 32'h7,         32'h0};
`endif
    tv[15] = '{8'h14, 1'b1, 32'h4,         32'h4};
    tv[16] = '{8'h14, 1'b1, 32'h0,         32'h0};
    clear_sched();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    prod_valid = 1'b1; dp_ready = 1'b1;
    #1;
    chk("rst rdata",  csr_rdata, 32'h0);
    chk("rst rvalid", csr_rvalid, 1'b0);
    chk("rst gates",  {prod_ready, dp_valid}, 2'b00);
    chk("rst mode",   mode, 2'd0);
    chk("rst kernel", kernel, KRST);
    chk("rst busy/done", {busy, frame_done}, 2'b00);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle gates", {prod_ready, dp_valid}, 2'b00);
    prod_valid = 1'b0;

    // Register map vectors
    for (int i = 0; i < 17; i++) begin
      if (tv[i].wr) csr_write(tv[i].a, tv[i].d);
      rd_chk($sformatf("csr vec %0d", i), tv[i].a, tv[i].exp);
    end
    chk("idle busy after vectors", busy, 1'b0);
    chk("active mode untouched", mode, 2'd0);
    chk("active kernel untouched", kernel, KRST);

    // Same-cycle read and write returns the old value
    csr_addr = 8'h00; csr_wdata = 32'h2; csr_wr = 1'b1; csr_rd = 1'b1;
    @(posedge clk); #1;
    csr_wr = 1'b0; csr_rd = 1'b0;
    chk("rd/wr same cycle old", csr_rdata, 32'h1);
    @(posedge clk); #1;
    chk("rvalid one-shot", csr_rvalid, 1'b0);
    rd_chk("rd after wr new", 8'h00, 32'h2);
    csr_write(8'h00, 32'h1);

    // Frame 1: mid-run config writes and a START while busy
    dp_ready = 1'b1;
    csr_write(8'h14, 32'h1);
    chk("f1 load busy", busy, 1'b1);
    chk("f1 load gate", prod_ready, 1'b0);
    sched[0] = '{100, 8'h00, 32'h2};
    sched[1] = '{101, 8'h04, 32'hFFFF_FFFF};
    sched[2] = '{200, 8'h14, 32'h1};
    stream(1024, 1'b0, 1'b1, "f1");
    chk("f1 mode held", mode, 2'd1);
    chk("f1 kernel held", kernel, K1);
    chk("f1 drain busy", busy, 1'b1);
    drain(3, 1, 2, 10, "f1");
    chk("f1 idle after", busy, 1'b0);
    rd_chk("f1 fcnt", 8'h18, 32'h1);
    rd_chk("f1 status", 8'h10, 32'h9);

    // Frame 2: STOP after 500 beats
    csr_write(8'h10, 32'hF);
    csr_write(8'h14, 32'h1);
    stream(499, 1'b0, 1'b0, "f2");
    chk("f2 mode loaded", mode, 2'd2);
    chk("f2 kernel loaded", kernel, K2);
    csr_write(8'h14, 32'h2);
    chk("stop busy", busy, 1'b0);
    chk("stop gates", {prod_ready, dp_valid}, 2'b00);
    rd_chk("stop status", 8'h10, 32'h2);
    rd_chk("stop fcnt", 8'h18, 32'h1);

    // Frame 3: random downstream ready, long stall in DRAIN
    csr_write(8'h14, 32'h1);
    stream(1024, 1'b1, 1'b1, "f3");
    drain(0, 0, 50, 54, "f3");
    rd_chk("f3 fcnt", 8'h18, 32'h2);
    rd_chk("f3 status", 8'h10, 32'h3);

    // Continuous mode: three frames, CONT cleared during the third
    csr_write(8'h10, 32'hF);
    csr_write(8'h14, 32'h5);
    for (int f = 0; f < 3; f++) begin
      if (f == 2) sched[0] = '{50, 8'h14, 32'h0};
      stream(1024, 1'b0, 1'b1, $sformatf("cont%0d", f));
      drain(0, 0, 0, 4, $sformatf("cont%0d", f));
      chk($sformatf("cont%0d next busy", f), busy, (f < 2) ? 1'b1 : 1'b0);
      if (f < 2) chk($sformatf("cont%0d load gate", f), prod_ready, 1'b0);
    end
    rd_chk("cont fcnt", 8'h18, 32'h5);
    rd_chk("cont ctrl", 8'h14, 32'h0);
    rd_chk("cont status", 8'h10, 32'h1);

    // Reset in the middle of a frame
    csr_write(8'h14, 32'h1);
    stream(100, 1'b0, 1'b0, "rstmid");
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("rstmid busy", busy, 1'b0);
    chk("rstmid gates", {prod_ready, dp_valid}, 2'b00);
    chk("rstmid mode", mode, 2'd0);
    chk("rstmid kernel", kernel, KRST);
    prod_valid = 1'b0;
    rd_chk("rstmid fcnt", 8'h18, 32'h0);
    rd_chk("rstmid shadow mode", 8'h00, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/proc_seq_ctrl.md
Name: proc_seq_ctrl

Overview:
Frame sequencer and CSR front-end for the pixel processing datapath. It holds the mode and 3x3 kernel configuration in shadow registers and commits them to the datapath only at frame boundaries. It gates the producer-to-datapath valid/ready handshake so that exactly one frame of IMG_W*IMG_H pixels is admitted per run. It monitors the datapath output to detect drain completion, and reports status and a frame count.

Parameters:
IMG_W, 32, pixels per line
IMG_H, 32, lines per frame
DRAIN_CYCLES, 4, consecutive output-idle cycles (with downstream ready) that end a drain
KERNEL_RST, 72'h00_0000_0001_0000_0000, kernel reset value (identity: centre weight 1)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
csr_addr  in  8  byte address
csr_wr  in  1  write strobe
csr_wdata  in  32  write data
csr_rd  in  1  read strobe
csr_rdata  out  32  read data, registered
csr_rvalid  out  1  one-cycle pulse, read data valid
prod_valid  in  1  producer valid
prod_ready  out  1  ready to producer
dp_valid  out  1  gated valid to datapath
dp_ready  in  1  datapath ready_in
dp_out_valid  in  1  datapath valid_out (monitor)
dp_out_ready  in  1  downstream ready (monitor)
mode  out  2  active mode to datapath
kernel  out  72  active kernel to datapath
busy  out  1  high in LOAD/RUN/DRAIN
frame_done  out  1  one-cycle pulse in DONE

Behaviour:
- Clock is clk. Reset is rstn, synchronous and active-low, sampled on the rising edge of clk. There is a single clock domain.
- Reset values: all outputs 0 except kernel=KERNEL_RST. All shadow copies equal their active values, frame_cnt=0, status=0, state=IDLE.
- Register map:
  - 0x00 MODE[1:0]
  - 0x04 KERN[31:0]
  - 0x08 KERN[63:32]
  - 0x0C KERN[71:64]
  - 0x10 STATUS (W1C): b0 DONE, b1 ABORT, b2 ERR_MODE, b3 ERR_BUSY, b4 busy (read-only)
  - 0x14 CTRL: b0 START, b1 STOP (self-clearing, read as 0), b2 CONT (sticky)
  - 0x18 FRAME_CNT[15:0] (read-only)
  - Unmapped addresses read 0; writes to them are ignored.
- CSR writes land one cycle after the csr_wr cycle. MODE and KERN writes update the shadow registers only.
- Writing MODE=3 leaves the shadow unchanged and sets ERR_MODE.
- Reads: csr_rdata and csr_rvalid are valid the cycle after csr_rd. A same-cycle rd and wr to the same address returns the old value.
- IDLE: prod_ready=0, dp_valid=0. START moves to LOAD. STOP is a no-op here.
- LOAD (1 cycle): copy shadow to active mode/kernel and clear the pixel counter, then go to RUN.
- RUN:
  - dp_valid=prod_valid, prod_ready=dp_ready (combinational pass-through).
  - The pixel counter increments on each prod_valid&&dp_ready beat.
  - The beat on which the counter equals IMG_W*IMG_H-1 moves the FSM to DRAIN. prod_ready and dp_valid are 0 from the next cycle.
- DRAIN:
  - Gates are closed. The idle counter increments on cycles with dp_out_ready=1 and no output beat.
  - An output beat (dp_out_valid&&dp_out_ready) resets the idle counter. Cycles with dp_out_ready=0 hold it.
  - Reaching DRAIN_CYCLES moves the FSM to DONE.
- DONE (1 cycle): frame_done=1, DONE bit set, FRAME_CNT+1 (wraps 0xFFFF to 0). Next state is LOAD if CONT=1, else IDLE.
- STOP in LOAD, RUN or DRAIN moves to IDLE the next cycle, sets ABORT, and leaves FRAME_CNT unchanged. Gates close in that same next cycle.
- START and STOP written together: STOP wins, and no run starts.
- START while busy is ignored and sets ERR_BUSY.
- Clearing CONT during a run lets the current frame finish and then return to IDLE.
- Mid-frame configuration writes never disturb the active mode/kernel. They apply at the next LOAD.
- When an event sets a STATUS bit in the same cycle as a W1C write clears it, the set wins.
- Reset asserted mid-frame returns the block to the reset state on the next edge. Any partially admitted frame is abandoned.

Optional Feature:
Macro PROC_SEQ_CTRL_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit) and register 0x1C IRQ_EN (b0 DONE, b1 ABORT, b2 ERR).
  - irq is registered and equals the OR over enabled STATUS bits of (STATUS & IRQ_EN). ERR is the OR of ERR_MODE and ERR_BUSY.
  - irq stays high until software clears the STATUS bits. Its reset value is 0.
- When undefined: no irq port, and 0x1C reads 0.

Decomposition:
- Package proc_seq_pkg holds:
  - register address localparams
  - STATUS and CTRL bit indices
  - mode encodings (BYPASS=0, INVERT=1, CONV=2, RSVD=3)
  - the state enum (IDLE, LOAD, RUN, DRAIN, DONE)
- One sub-module, proc_seq_regs: CSR decode, shadow and active registers, STATUS W1C logic, and read mux.
- The top level holds the FSM, pixel counter, idle counter and handshake gating.

Test Plan:
- Write MODE=1 then START, stream 1024 pixels with dp_ready=1 → exactly 1024 dp_valid beats; prod_ready drops the cycle after beat 1024. Then DRAIN_CYCLES idle cycles, a frame_done pulse, and FRAME_CNT=1.
- During RUN write MODE=2 and KERN=0xFF.. → mode/kernel outputs unchanged until the next LOAD, then mode=2.
- Write MODE=3 → ERR_MODE=1 and the MODE readback is unchanged. Write 0x04 to STATUS → ERR_MODE=0.
- STOP after 500 beats → IDLE the next cycle, ABORT=1, FRAME_CNT unchanged, prod_ready=0. A new START then admits a full 1024 pixels.
- CONT=1 with START, 3 frames streamed → 3 frame_done pulses, one LOAD cycle between frames, FRAME_CNT=3. Clear CONT during frame 3 → IDLE after it.
- Toggle dp_ready randomly (50%) with prod_valid=1 → beat count is still exactly 1024. Hold dp_out_ready=0 in DRAIN → the FSM stays in DRAIN indefinitely.
